// File: rtl/stage_interrupt_controller_pkg.sv
// rtl/stage_interrupt_controller_pkg.sv - state encoding and flag layout shared by the sequencer
package stage_interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_IRQ_SAVE  = 3'd5
  } state_e;

  localparam int DEF_FLAG_W = 3;

  // Flag bundle is ordered {cout, zero, overflow}
  localparam int FLAG_COUT = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  localparam logic [7:0] DEF_ISR_VECTOR = 8'hF0;

endpackage

// File: rtl/stage_interrupt_controller_irq_edge_latch.sv
// rtl/stage_interrupt_controller_irq_edge_latch.sv - rising-edge interrupt capture with clear
module stage_interrupt_controller_irq_edge_latch
  import stage_interrupt_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic arm_en,
  input  logic clr,
  input  logic clr_start,
  output logic pending
);

  logic irq_prev_q, irq_prev_d;
  logic pending_q, pending_d;
  logic set_edge;

  // A new edge wins over a same-cycle clear so it is never lost
  always_comb begin
    irq_prev_d = irq_in;
    set_edge   = irq_in & ~irq_prev_q & arm_en;
    pending_d  = pending_q;
    if (clr | clr_start) pending_d = 1'b0;
    if (set_edge)        pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/stage_interrupt_controller.sv
// rtl/stage_interrupt_controller.sv - four-stage instruction sequencer with PC and interrupt entry/return
module stage_interrupt_controller
  import stage_interrupt_controller_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] ISR_VECTOR = PC_W'(DEF_ISR_VECTOR),
  parameter int              FLAG_W     = DEF_FLAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartEverything,
  input  logic              interrupt,
  input  logic              opIsHalt,
  input  logic              opIsRti,
  input  logic              opBranchTaken,
  input  logic [PC_W-1:0]   branchTarget,
  input  logic [FLAG_W-1:0] flagsIn,
  output logic [PC_W-1:0]   pc,
  output logic              irEn,
  output logic              decEn,
  output logic              accEn,
  output logic              flagsRestore,
  output logic [FLAG_W-1:0] flagsSaved,
  output logic              StageComplete,
  output logic              inIsr,
  output logic              running
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
  logic [FLAG_W-1:0] flags_saved_q, flags_saved_d;
  logic              in_isr_q, in_isr_d;
  logic [PC_W-1:0]   next_pc;
  logic              irq_pending;
  logic              start_go;
  logic              irq_take;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    saved_pc_d    = saved_pc_q;
    flags_saved_d = flags_saved_q;
    in_isr_d      = in_isr_q;
    start_go      = 1'b0;
    irq_take      = 1'b0;
    next_pc       = opIsRti       ? saved_pc_q :
                    opBranchTaken ? branchTarget :
                                    pc_q + PC_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (StartEverything) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          start_go = 1'b1;
        end
      end
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        // A pending request inside the ISR waits until RTI plus one instruction
        if (opIsHalt) begin
          state_d = ST_IDLE;
        end else if (opIsRti) begin
          state_d  = ST_FETCH;
          pc_d     = saved_pc_q;
          in_isr_d = 1'b0;
        end else if (irq_pending && !in_isr_q) begin
          state_d    = ST_IRQ_SAVE;
          saved_pc_d = next_pc;
        end else begin
          state_d = ST_FETCH;
          pc_d    = next_pc;
        end
      end
      ST_IRQ_SAVE: begin
        state_d       = ST_FETCH;
        flags_saved_d = flagsIn;
        pc_d          = ISR_VECTOR;
        in_isr_d      = 1'b1;
        irq_take      = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      saved_pc_q    <= '0;
      flags_saved_q <= '0;
      in_isr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      saved_pc_q    <= saved_pc_d;
      flags_saved_q <= flags_saved_d;
      in_isr_q      <= in_isr_d;
    end
  end

  stage_interrupt_controller_irq_edge_latch u_irq_latch (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (interrupt),
    .arm_en    (state_q != ST_IDLE),
    .clr       (irq_take),
    .clr_start (start_go),
    .pending   (irq_pending)
  );

  assign pc            = pc_q;
  assign irEn          = (state_q == ST_FETCH);
  assign decEn         = (state_q == ST_DECODE);
  assign accEn         = (state_q == ST_EXECUTE) & ~opIsHalt & ~opIsRti;
  assign StageComplete = (state_q == ST_WRITEBACK);
  assign flagsRestore  = (state_q == ST_WRITEBACK) & opIsRti & ~opIsHalt;
  assign flagsSaved    = flags_saved_q;
  assign inIsr         = in_isr_q;
  assign running       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stage_interrupt_controller.sv
// tb/tb_stage_interrupt_controller.sv - scoreboard bench for the sequencer with a table-driven program model
module tb_stage_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset, StartEverything, interrupt;
  logic       opIsHalt, opIsRti, opBranchTaken;
  logic [7:0] branchTarget, pc;
  logic [2:0] flagsIn, flagsSaved;
  logic       irEn, decEn, accEn, flagsRestore, StageComplete, inIsr, running;

  logic       prog_halt [256];
  logic       prog_rti  [256];
  logic       prog_br   [256];
  logic [7:0] prog_tgt  [256];

  typedef struct packed {
    logic [7:0] pc;
    logic       isr;
  } fetch_t;

  fetch_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cnt_ir = 0, cnt_dec = 0, cnt_acc = 0, cnt_sc = 0, cnt_run = 0, cnt_fr = 0;

  always #10 clk = ~clk;

  assign opIsHalt      = prog_halt[pc];
  assign opIsRti       = prog_rti[pc];
  assign opBranchTaken = prog_br[pc];
  assign branchTarget  = prog_tgt[pc];

  stage_interrupt_controller dut (
    .clk            (clk),
    .reset          (reset),
    .StartEverything(StartEverything),
    .interrupt      (interrupt),
    .opIsHalt       (opIsHalt),
    .opIsRti        (opIsRti),
    .opBranchTaken  (opBranchTaken),
    .branchTarget   (branchTarget),
    .flagsIn        (flagsIn),
    .pc             (pc),
    .irEn           (irEn),
    .decEn          (decEn),
    .accEn          (accEn),
    .flagsRestore   (flagsRestore),
    .flagsSaved     (flagsSaved),
    .StageComplete  (StageComplete),
    .inIsr          (inIsr),
    .running        (running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every FETCH is compared against the next expected fetch record
  always @(negedge clk) begin : monitor
    fetch_t e;
    if (!reset) begin
      if (irEn)          cnt_ir++;
      if (decEn)         cnt_dec++;
      if (accEn)         cnt_acc++;
      if (StageComplete) cnt_sc++;
      if (running)       cnt_run++;
      if (flagsRestore)  cnt_fr++;
      if (irEn) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch: got pc %0h expected no fetch", pc);
        end else begin
          e = exp_q.pop_front();
          check("fetch_pc", {24'b0, pc}, {24'b0, e.pc});
          check("fetch_isr", {31'b0, inIsr}, {31'b0, e.isr});
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog_halt[i] = 1'b0;
      prog_rti[i]  = 1'b0;
      prog_br[i]   = 1'b0;
      prog_tgt[i]  = 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic isr);
    fetch_t f;
    f.pc  = a;
    f.isr = isr;
    exp_q.push_back(f);
  endtask

  task automatic start();
    @(negedge clk);
    StartEverything = 1'b1;
    @(negedge clk);
    StartEverything = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (running && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, running}, 32'd0);
  endtask

  // which: 0 irEn, 1 decEn, 2 accEn, 3 StageComplete
  task automatic wait_strobe(input int which, input logic [7:0] addr, input string name);
    logic hit = 1'b0;
    logic s;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      s = (which == 0) ? irEn : (which == 1) ? decEn : (which == 2) ? accEn : StageComplete;
      hit = s && (pc == addr);
    end
    check(name, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_ir, s_dec, s_acc, s_sc, s_run, s_fr;
    reset = 1'b1;
    StartEverything = 1'b0;
    interrupt = 1'b0;
    flagsIn = 3'b000;
    clear_prog();
    repeat (2) @(negedge clk);
    check("rst_pc", {24'b0, pc}, 32'd0);
    check("rst_running", {31'b0, running}, 32'd0);
    check("rst_strobes", {28'b0, irEn, decEn, accEn, StageComplete}, 32'd0);
    check("rst_inisr", {31'b0, inIsr}, 32'd0);
    check("rst_flags_saved", {29'b0, flagsSaved}, 32'd0);
    reset = 1'b0;

    // Straight-line code ending in HALT, with an ignored start pulse mid-run
    clear_prog();
    prog_halt[3] = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(i), 1'b0);
    s_ir = cnt_ir; s_dec = cnt_dec; s_acc = cnt_acc; s_sc = cnt_sc; s_run = cnt_run;
    start();
    repeat (5) @(negedge clk);
    StartEverything = 1'b1;
    @(negedge clk);
    StartEverything = 1'b0;
    wait_idle("A_idle");
    check("A_irEn_cnt", cnt_ir - s_ir, 32'd4);
    check("A_decEn_cnt", cnt_dec - s_dec, 32'd4);
    check("A_accEn_cnt", cnt_acc - s_acc, 32'd3);
    check("A_stage_complete_cnt", cnt_sc - s_sc, 32'd4);
    check("A_running_cycles", cnt_run - s_run, 32'd16);
    check("A_halt_pc", {24'b0, pc}, 32'd3);

    // Taken branch at pc 2
    clear_prog();
    prog_br[2] = 1'b1;
    prog_tgt[2] = 8'h40;
    prog_halt[8'h40] = 1'b1;
    push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h40, 1'b0);
    start();
    wait_idle("B_idle");
    check("B_inisr", {31'b0, inIsr}, 32'd0);

    // Interrupt at pc 5, second held-high interrupt inside the ISR
    clear_prog();
    prog_rti[8'hF1] = 1'b1;
    prog_halt[8] = 1'b1;
    flagsIn = 3'b101;
    s_fr = cnt_fr;
    for (int i = 0; i < 6; i++) push(8'(i), 1'b0);
    push(8'hF0, 1'b1); push(8'hF1, 1'b1); push(8'h06, 1'b0);
    push(8'hF0, 1'b1); push(8'hF1, 1'b1); push(8'h07, 1'b0); push(8'h08, 1'b0);
    start();
    wait_strobe(2, 8'h05, "C_exec5");
    #1 interrupt = 1'b1;
    #30 interrupt = 1'b0;
    wait_strobe(2, 8'hF0, "C_exec_isr");
    check("C_flags_saved1", {29'b0, flagsSaved}, 32'b101);
    check("C_inisr", {31'b0, inIsr}, 32'd1);
    #1 interrupt = 1'b1;
    flagsIn = 3'b010;
    wait_idle("C_idle");
    interrupt = 1'b0;
    check("C_flags_saved2", {29'b0, flagsSaved}, 32'b010);
    check("C_restore_cnt", cnt_fr - s_fr, 32'd2);
    check("C_inisr_end", {31'b0, inIsr}, 32'd0);

    // RTI outside the ISR returns to the last saved PC (7)
    clear_prog();
    prog_rti[1] = 1'b1;
    prog_halt[7] = 1'b1;
    flagsIn = 3'b000;
    s_fr = cnt_fr;
    push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h07, 1'b0);
    start();
    wait_idle("G_idle");
    check("G_restore_cnt", cnt_fr - s_fr, 32'd1);
    check("G_pc", {24'b0, pc}, 32'd7);

    // HALT with an interrupt edge in its WRITEBACK; restart discards it
    clear_prog();
    prog_halt[4] = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(i), 1'b0);
    start();
    wait_strobe(3, 8'h04, "D_wb4");
    #1 interrupt = 1'b1;
    @(negedge clk);
    check("D_running", {31'b0, running}, 32'd0);
    check("D_pc_hold", {24'b0, pc}, 32'd4);
    interrupt = 1'b0;
    clear_prog();
    prog_halt[1] = 1'b1;
    push(8'h00, 1'b0); push(8'h01, 1'b0);
    start();
    wait_idle("D_restart_idle");
    check("D_restart_pc", {24'b0, pc}, 32'd1);

    // Reset asserted during DECODE
    clear_prog();
    push(8'h00, 1'b0); push(8'h01, 1'b0);
    start();
    wait_strobe(1, 8'h01, "E_dec1");
    #1 reset = 1'b1;
    #1;
    check("E_running", {31'b0, running}, 32'd0);
    check("E_pc", {24'b0, pc}, 32'd0);
    check("E_inisr", {31'b0, inIsr}, 32'd0);
    check("E_strobes", {27'b0, irEn, decEn, accEn, StageComplete, flagsRestore}, 32'd0);
    check("E_flags_saved", {29'b0, flagsSaved}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // PC wraps from 0xFF to 0x00
    clear_prog();
    prog_br[0] = 1'b1;
    prog_tgt[0] = 8'hFF;
    push(8'h00, 1'b0); push(8'hFF, 1'b0); push(8'h00, 1'b0);
    start();
    wait_strobe(0, 8'hFF, "F_fetchFF");
    prog_br[0] = 1'b0;
    prog_halt[0] = 1'b1;
    wait_idle("F_idle");
    check("F_wrap_pc", {24'b0, pc}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
